// File: rtl/lru_pkg.sv
// Shared limits, index-width helper, response struct and popcount helper for
// the per-set matrix LRU tracker.
package lru_pkg;

    localparam int WAYS_MIN = 2;
    localparam int WAYS_MAX = 16;
    localparam int SETS_MIN = 1;
    localparam int WAYW_MAX = 4;

    // Index width for n entries; a single entry still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int k = 0; k < 16; k++) begin
            c = c + {4'd0, v[k]};
        end
        return c;
    endfunction

    typedef struct packed {
        logic [WAYW_MAX-1:0] way;
        logic                miss;
        logic                lock_err;
    } lru_resp_t;

endpackage

// File: rtl/lru_victim_sel.sv
// Combinational victim picker for one set's recency matrix.
// With LRU_WAY_LOCK_EN defined, locked ways are skipped when any way is unlocked.
module lru_victim_sel
    import lru_pkg::*;
#(
    parameter  int WAYS = 8,
    localparam int WAYW = idx_width(WAYS)
) (
    input  logic [WAYS-1:0][WAYS-1:0] mat_i,
`ifdef LRU_WAY_LOCK_EN
    input  logic [WAYS-1:0]           lock_mask_i,
    output logic                      all_locked_o,
`endif
    output logic [WAYW-1:0]           victim_o
);

    logic [WAYS-1:0] row_zero_s;
    logic [WAYW-1:0] lru_way_s;

    // A way whose row holds no 1s is more recent than nobody: it is a victim candidate.
    always_comb begin
        row_zero_s = '0;
        for (int i = 0; i < WAYS; i++) begin
            row_zero_s[i] = ~|(mat_i[i] & ~(WAYS'(1) << i));
        end
    end

    // Descending scan so the lowest candidate index is the one left standing.
    always_comb begin
        lru_way_s = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (row_zero_s[i]) begin
                lru_way_s = WAYW'(i);
            end else begin
                lru_way_s = lru_way_s;
            end
        end
    end

`ifdef LRU_WAY_LOCK_EN
    logic [WAYW-1:0] best_way_s;
    logic [4:0]      best_cnt_s;
    logic [4:0]      cnt_s;

    // Least recent unlocked way = fewest 1s in its row; strict compare keeps ties at the lowest index.
    always_comb begin
        best_way_s = '0;
        best_cnt_s = 5'h1f;
        cnt_s      = 5'd0;
        for (int i = 0; i < WAYS; i++) begin
            cnt_s = popcount16(16'(mat_i[i] & ~(WAYS'(1) << i)));
            if (!lock_mask_i[i] && (cnt_s < best_cnt_s)) begin
                best_cnt_s = cnt_s;
                best_way_s = WAYW'(i);
            end else begin
                best_cnt_s = best_cnt_s;
            end
        end
    end

    assign all_locked_o = &lock_mask_i;
    assign victim_o     = all_locked_o ? lru_way_s : best_way_s;
`else
    assign victim_o = lru_way_s;
`endif

endmodule

// File: rtl/matrix_lru_sets.sv
// Matrix-based true-LRU tracker with one WAYS x WAYS recency matrix per set.
// Optional way locking is enabled by defining LRU_WAY_LOCK_EN.
module matrix_lru_sets
    import lru_pkg::*;
#(
    parameter  int WAYS = 8,
    parameter  int SETS = 4,
    localparam int WAYW = idx_width(WAYS),
    localparam int SETW = idx_width(SETS)
) (
    input  logic            clk,
    input  logic            reset,
`ifdef LRU_WAY_LOCK_EN
    input  logic [WAYS-1:0] lock_mask,
    output logic            resp_lock_err,
`endif
    input  logic            req_valid,
    input  logic [SETW-1:0] req_set,
    input  logic            req_hit,
    input  logic [WAYW-1:0] req_way,
    output logic            resp_valid,
    output logic [WAYW-1:0] resp_way,
    output logic            resp_miss
);

    typedef logic [WAYS-1:0][WAYS-1:0] mat_t;

    mat_t      mat_q [SETS];
    mat_t      mat_d [SETS];
    mat_t      cur_mat_s;
    logic      resp_valid_q;
    lru_resp_t resp_q;
    lru_resp_t resp_d;
    logic [WAYW-1:0] victim_s;
    logic [WAYW-1:0] touch_way_s;
    logic      unused_s;

    // Read mux: pick the addressed set's matrix for victim selection.
    always_comb begin
        cur_mat_s = '0;
        for (int s = 0; s < SETS; s++) begin
            cur_mat_s = cur_mat_s | ((req_set == SETW'(s)) ? mat_q[s] : '0);
        end
    end

`ifdef LRU_WAY_LOCK_EN
    logic all_locked_s;

    lru_victim_sel #(.WAYS(WAYS)) u_victim_sel (
        .mat_i        (cur_mat_s),
        .lock_mask_i  (lock_mask),
        .all_locked_o (all_locked_s),
        .victim_o     (victim_s)
    );
`else
    lru_victim_sel #(.WAYS(WAYS)) u_victim_sel (
        .mat_i    (cur_mat_s),
        .victim_o (victim_s)
    );
`endif

    assign touch_way_s = req_hit ? req_way : victim_s;

    // Touch: set the touched way's row, clear its column; the diagonal is never kept.
    always_comb begin
        mat_d = mat_q;
        for (int s = 0; s < SETS; s++) begin
            if (req_valid && (req_set == SETW'(s))) begin
                for (int i = 0; i < WAYS; i++) begin
                    for (int j = 0; j < WAYS; j++) begin
                        if (i == j) begin
                            mat_d[s][i][j] = 1'b0;
                        end else if (WAYW'(i) == touch_way_s) begin
                            mat_d[s][i][j] = 1'b1;
                        end else if (WAYW'(j) == touch_way_s) begin
                            mat_d[s][i][j] = 1'b0;
                        end else begin
                            mat_d[s][i][j] = mat_q[s][i][j];
                        end
                    end
                end
            end else begin
                mat_d[s] = mat_q[s];
            end
        end
    end

    // Response next-state: capture on a request, otherwise hold.
    always_comb begin
        resp_d = resp_q;
        if (req_valid) begin
            resp_d.way  = WAYW_MAX'(touch_way_s);
            resp_d.miss = ~req_hit;
`ifdef LRU_WAY_LOCK_EN
            resp_d.lock_err = ~req_hit & all_locked_s;
`else
            resp_d.lock_err = 1'b0;
`endif
        end else begin
            resp_d = resp_q;
        end
    end

    // State and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                mat_q[s] <= '0;
            end
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
        end else begin
            mat_q        <= mat_d;
            resp_valid_q <= req_valid;
            resp_q       <= resp_d;
        end
    end

    // A response falling due in a reset cycle is suppressed.
    assign resp_valid = resp_valid_q & ~reset;
    assign resp_way   = resp_q.way[WAYW-1:0];
    assign resp_miss  = resp_q.miss;
`ifdef LRU_WAY_LOCK_EN
    assign resp_lock_err = resp_q.lock_err;
`endif
    assign unused_s = ^{resp_q.way, resp_q.lock_err};

endmodule

// File: tb/tb_matrix_lru_sets.sv
// Self-checking bench for matrix_lru_sets: directed scenarios plus randomized
// traffic checked against a timestamp-based recency model.
module tb_matrix_lru_sets;

    localparam int WAYS = 8;
    localparam int SETS = 4;
    localparam int WAYW = 3;
    localparam int SETW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic [SETW-1:0] req_set;
    logic            req_hit;
    logic [WAYW-1:0] req_way;
    logic            resp_valid;
    logic [WAYW-1:0] resp_way;
    logic            resp_miss;
    logic [WAYS-1:0] lock_mask;
`ifdef LRU_WAY_LOCK_EN
    logic            resp_lock_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Model: last-use timestamp per way, -1 = never used since reset.
    int last_use [SETS][WAYS];
    int stamp;

    matrix_lru_sets dut (
        .clk           (clk),
        .reset         (reset),
`ifdef LRU_WAY_LOCK_EN
        .lock_mask     (lock_mask),
        .resp_lock_err (resp_lock_err),
`endif
        .req_valid     (req_valid),
        .req_set       (req_set),
        .req_hit       (req_hit),
        .req_way       (req_way),
        .resp_valid    (resp_valid),
        .resp_way      (resp_way),
        .resp_miss     (resp_miss)
    );

    always #5 clk = ~clk;

    function void model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                last_use[s][w] = -1;
        stamp = 0;
    endfunction

    // Least recently used way; unused ways count as oldest, lowest index wins ties.
    function int model_victim(input int s, input logic [WAYS-1:0] mask);
        int best;
        best = -1;
        for (int w = 0; w < WAYS; w++)
            if (!mask[w] && (best < 0 || last_use[s][w] < last_use[s][best])) best = w;
        if (best < 0) begin
            best = 0;
            for (int w = 1; w < WAYS; w++)
                if (last_use[s][w] < last_use[s][best]) best = w;
        end
        return best;
    endfunction

    function void model_touch(input int s, input int w);
        last_use[s][w] = stamp;
        stamp++;
    endfunction

    task automatic drive(input logic v, input int s, input logic h, input int w);
        @(negedge clk);
        req_valid = v;
        req_set   = SETW'(s);
        req_hit   = h;
        req_way   = WAYW'(w);
        @(posedge clk);
        #1;
    endtask

    task automatic access(input int s, input logic h, input int w, output int exp_w);
        exp_w = h ? w : model_victim(s, lock_mask);
        model_touch(s, exp_w);
        drive(1'b1, s, h, w);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_set   = '0;
        req_hit   = 1'b0;
        req_way   = '0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int e;
        do_reset();
        access(0, 1'b1, 5, e);
        do_reset();
        n_checks++;
        if ({resp_valid, resp_miss, resp_way} !== 5'b0)
            $display("FAIL reset_state: got v/miss/way=%b expected 00000", {resp_valid, resp_miss, resp_way});
        else n_pass++;
        access(0, 1'b0, 0, e);
        n_checks++;
        if ({resp_valid, resp_miss, resp_way} !== {1'b1, 1'b1, 3'd0})
            $display("FAIL reset_first_miss: got %b expected %b", {resp_valid, resp_miss, resp_way}, {1'b1, 1'b1, 3'd0});
        else n_pass++;
    endtask

    task automatic test_hits_then_miss();
        int e;
        do_reset();
        for (int w = 0; w < WAYS; w++) begin
            access(0, 1'b1, w, e);
            n_checks++;
            if ({resp_valid, resp_miss, resp_way} !== {1'b1, 1'b0, WAYW'(w)})
                $display("FAIL hit_echo way %0d: got %b expected %b", w, {resp_valid, resp_miss, resp_way}, {1'b1, 1'b0, WAYW'(w)});
            else n_pass++;
        end
        access(0, 1'b0, 0, e);
        n_checks++;
        if ({resp_valid, resp_miss, resp_way} !== {1'b1, 1'b1, 3'd0})
            $display("FAIL miss_after_hits: got %b expected %b", {resp_valid, resp_miss, resp_way}, {1'b1, 1'b1, 3'd0});
        else n_pass++;
    endtask

    task automatic test_miss_order();
        int e;
        logic [WAYW-1:0] exp_way;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            exp_way = WAYW'(k % WAYS);
            access(1, 1'b0, 0, e);
            n_checks++;
            if ({resp_valid, resp_miss, resp_way} !== {1'b1, 1'b1, exp_way})
                $display("FAIL miss_order #%0d: got way %0d expected %0d", k, resp_way, exp_way);
            else n_pass++;
        end
    endtask

    task automatic test_set_independence();
        int e;
        do_reset();
        for (int w = 0; w < 7; w++) access(2, 1'b1, w, e);
        access(3, 1'b0, 0, e);
        n_checks++;
        if (resp_way !== 3'd0) $display("FAIL set3_miss: got way %0d expected 0", resp_way);
        else n_pass++;
        access(2, 1'b0, 0, e);
        n_checks++;
        if (resp_way !== 3'd7) $display("FAIL set2_miss: got way %0d expected 7", resp_way);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int e;
        logic [WAYW-1:0] exp_seq [3];
        exp_seq[0] = 3'd1;
        exp_seq[1] = 3'd2;
        exp_seq[2] = 3'd4;
        do_reset();
        access(0, 1'b1, 3, e);
        access(0, 1'b1, 0, e);
        for (int k = 0; k < 3; k++) begin
            access(0, 1'b0, 0, e);
            n_checks++;
            if ({resp_valid, resp_miss, resp_way} !== {1'b1, 1'b1, exp_seq[k]})
                $display("FAIL b2b_miss #%0d: got way %0d expected %0d", k, resp_way, exp_seq[k]);
            else n_pass++;
        end
    endtask

    task automatic test_midstream_reset();
        int e;
        do_reset();
        access(0, 1'b1, 0, e);
        access(0, 1'b0, 0, e);
        reset     = 1'b1;
        req_valid = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b0) $display("FAIL midreset_suppress: resp_valid=%b expected 0", resp_valid);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if ({resp_valid, resp_miss, resp_way} !== 5'b0)
            $display("FAIL midreset_clear: got %b expected 00000", {resp_valid, resp_miss, resp_way});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        access(0, 1'b0, 0, e);
        n_checks++;
        if (resp_way !== 3'd0) $display("FAIL midreset_next_miss: got way %0d expected 0", resp_way);
        else n_pass++;
    endtask

    task automatic test_idle_hold();
        int e;
        do_reset();
        access(1, 1'b1, 6, e);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, k, 1'b0, k);
            n_checks++;
            if ({resp_valid, resp_miss, resp_way} !== {1'b0, 1'b0, 3'd6})
                $display("FAIL idle_hold #%0d: got %b expected %b", k, {resp_valid, resp_miss, resp_way}, {1'b0, 1'b0, 3'd6});
            else n_pass++;
        end
    endtask

`ifdef LRU_WAY_LOCK_EN
    task automatic test_way_lock();
        int e;
        do_reset();
        lock_mask = 8'h01;
        access(0, 1'b0, 0, e);
        n_checks++;
        if ({resp_lock_err, resp_way} !== {1'b0, 3'd1})
            $display("FAIL lock_skip: got err/way=%b expected 0001", {resp_lock_err, resp_way});
        else n_pass++;
        lock_mask = 8'hFF;
        access(0, 1'b0, 0, e);
        n_checks++;
        if ({resp_lock_err, resp_way} !== {1'b1, 3'd0})
            $display("FAIL lock_all: got err/way=%b expected 1000", {resp_lock_err, resp_way});
        else n_pass++;
        lock_mask = '0;
    endtask
`endif

    task automatic test_random();
        int e, s, w;
        logic v, h;
        logic [WAYW-1:0] prev_way;
        logic            prev_miss;
        logic [4:0]      exp_vec;
        do_reset();
        prev_way  = '0;
        prev_miss = 1'b0;
        for (int k = 0; k < 400; k++) begin
            v = ($urandom % 5) != 0;
            s = $urandom % SETS;
            h = $urandom % 2;
            w = $urandom % WAYS;
`ifdef LRU_WAY_LOCK_EN
            case ($urandom % 4)
                0:       lock_mask = '0;
                1:       lock_mask = '1;
                default: lock_mask = WAYS'($urandom);
            endcase
`endif
            if (v) begin
                access(s, h, w, e);
                exp_vec   = {1'b1, ~h, WAYW'(e)};
                prev_way  = WAYW'(e);
                prev_miss = ~h;
            end else begin
                drive(1'b0, s, h, w);
                exp_vec = {1'b0, prev_miss, prev_way};
            end
            n_checks++;
            if ({resp_valid, resp_miss, resp_way} !== exp_vec)
                $display("FAIL random #%0d: got %b expected %b", k, {resp_valid, resp_miss, resp_way}, exp_vec);
            else n_pass++;
`ifdef LRU_WAY_LOCK_EN
            if (v) begin
                n_checks++;
                if (resp_lock_err !== (~h & (&lock_mask)))
                    $display("FAIL random_lock_err #%0d: got %b expected %b", k, resp_lock_err, ~h & (&lock_mask));
                else n_pass++;
            end
`endif
        end
        lock_mask = '0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_set   = '0;
        req_hit   = 1'b0;
        req_way   = '0;
        lock_mask = '0;
        model_reset();
        test_reset();
        test_hits_then_miss();
        test_miss_order();
        test_set_independence();
        test_back_to_back();
        test_midstream_reset();
        test_idle_hold();
`ifdef LRU_WAY_LOCK_EN
        test_way_lock();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
